rep_det_sched: RTL
==================

// Module: rep_det_sched
// PURPOSE
//  Owns the game-history stack feeding one rep_det instance and shares its query port among NUM_REQ requesters.
//  Search pushes/pops positions as moves are made/unmade. Requesters submit board+castle_mask and get a thrice-rep verdict.
//  Sits between the search controllers and rep_det. Drives all rep_det inputs; integration ties rep_det.reset = ~reset_n.
// PARAMETERS
//  REPDET_WIDTH  8  history address width; must equal rep_det REPDET_WIDTH; max depth 2^REPDET_WIDTH-1
//  NUM_REQ       4  number of query requesters (>=1)
// PORTS
//  clk                  in   1                      clock
//  reset_n              in   1                      async active-low reset
//  hist_push            in   1                      push hist_board/hist_castle_mask
//  hist_pop             in   1                      pop top entry
//  hist_clear           in   1                      empty the history
//  hist_board           in   `BOARD_WIDTH           position to push
//  hist_castle_mask     in   4                      castle mask to push
//  hist_ready           out  1                      history ops accepted this cycle
//  hist_depth           out  REPDET_WIDTH           current entry count
//  hist_full/hist_empty out  1                      depth==2^W-1 / depth==0
//  hist_overflow        out  1                      sticky: push refused while full; cleared by hist_clear
//  req_valid            in   NUM_REQ                query request, held until req_ready
//  req_board            in   NUM_REQ*`BOARD_WIDTH   per-requester board, slice i
//  req_castle_mask      in   NUM_REQ*4              per-requester castle mask, slice i
//  req_ready            out  NUM_REQ                one-hot 1-cycle accept
//  rsp_valid            out  NUM_REQ                one-hot 1-cycle verdict strobe
//  rsp_rep              out  1                      verdict, qualified by rsp_valid
//  rd_board/rd_castle_mask      out  `BOARD_WIDTH/4          -> rep_det board_in/castle_mask_in
//  rd_board_valid/rd_clear_sample out 1                     -> rep_det board_valid/clear_sample
//  rd_ram_board/rd_ram_castle_mask out `BOARD_WIDTH/4        -> rep_det ram_board_in/ram_castle_mask_in
//  rd_ram_wr_addr/rd_ram_depth  out  REPDET_WIDTH            -> rep_det ram_wr_addr_in/ram_depth_in
//  rd_ram_wr_en                 out  1                       -> rep_det ram_wr_en
//  rd_thrice_rep/rd_thrice_rep_valid in 1                    <- rep_det outputs
// BEHAVIOUR
//  Reset: every output and register 0 (depth 0, overflow 0, rr pointer 0); hist_ready=1 and hist_empty=1 combinationally.
//  History: hist_ready = (state==IDLE). Ops presented while hist_ready=0 are ignored; the master holds them.
//   Priority: clear > push&pop > push > pop.
//   Clear: depth<=0 and overflow<=0.
//   Push: write at addr depth, then depth+1. When full, no write, depth unchanged, and overflow<=1.
//   Pop: depth-1. Pop when empty is ignored.
//   push&pop: overwrite addr depth-1 with depth unchanged. When empty, behaves as push.
//  RAM write path: rd_ram_wr_en/addr/data are registered, 1 cycle after the op. rd_ram_depth=hist_depth.
//  FSM IDLE->ISSUE->WAIT->DRAIN->IDLE.
//  IDLE: if any req_valid and no hist op this cycle, grant round-robin, starting at the index after the last grant.
//   Latch the granted slice into rd_board/rd_castle_mask and go to ISSUE. Any hist op in the same cycle wins; the grant retries next cycle.
//   A grant is blocked for 1 cycle after an op so the RAM write lands first.
//  ISSUE: rd_board_valid=1 and req_ready[g]=1 for exactly this cycle, then WAIT.
//  WAIT: on rd_thrice_rep_valid=1, rsp_rep<=rd_thrice_rep, rsp_valid[g]<=1 for 1 cycle, rd_clear_sample<=1 for 1 cycle, then DRAIN.
//  DRAIN: hold until rd_thrice_rep_valid==0, then IDLE and rr pointer<=g.
//  Min req_ready latency 1 cycle after req_valid seen in IDLE.
//  Never more than one query in flight. Depth is frozen while not IDLE.
//  Async reset mid-query aborts it: no rsp_valid, depth 0. Requesters re-issue after reset release.
// TESTING
//  1 push A,B,A,B,A; req0 queries A -> rsp_valid[0], rsp_rep=1; req1 queries B -> rsp_rep=0.
//  2 push A,A (depth 2); query A -> rsp_rep=0 (rep_det depth<3 path); depth stays 2.
//  3 req_valid=4'b1111 held from reset -> req_ready order 0,1,2,3, each rsp_valid one-hot, no overlap.
//  4 W=3: 7 pushes -> depth 7, full=1; 8th push ignored, overflow=1; 8 pops -> depth 0, last pop ignored; clear -> overflow 0.
//  5 push A,B; then push&pop C -> depth 2, RAM addr1=C; query C with A,C,C history after another push C -> rsp_rep=0; third C pushed -> 1.
//  6 reset_n low during WAIT -> all outputs 0, depth 0; after release, push A x3 and query A -> rsp_rep=1.

Source files
------------

// File: rtl/rep_det_sched.sv
// ---------------------------------------------------------------------------
// rep_det_sched
//
// Purpose:
//   Owns the game-history stack that feeds a single rep_det instance and
//   shares that instance's query port among NUM_REQ requesters. The search
//   pushes and pops positions as moves are made and unmade. Requesters
//   submit a board plus castle mask and get back a thrice-repetition verdict.
//   Only one query is in flight at a time. The history depth is frozen while
//   a query is in flight.
//
// Parameters:
//   REPDET_WIDTH  history address width (max depth 2^REPDET_WIDTH-1)
//   NUM_REQ       number of query requesters (>=1)
//
// Ports:
//   clk, reset_n                        clock, async active-low reset
//   hist_push/hist_pop/hist_clear       history operations (clear > push&pop > push > pop)
//   hist_board, hist_castle_mask        entry to push
//   hist_ready                          history ops accepted this cycle (scheduler idle)
//   hist_depth, hist_full, hist_empty   stack occupancy
//   hist_overflow                       sticky push-while-full flag, cleared by hist_clear
//   req_valid/req_board/req_castle_mask per-requester query, held until req_ready
//   req_ready                           one-hot single-cycle accept
//   rsp_valid, rsp_rep                  one-hot verdict strobe and verdict
//   rd_*                                rep_det query and history-RAM interface
// ---------------------------------------------------------------------------
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 256
`endif

module rep_det_sched #(
    parameter int REPDET_WIDTH = 8,
    parameter int NUM_REQ      = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              hist_push,
    input  logic                              hist_pop,
    input  logic                              hist_clear,
    input  logic [`BOARD_WIDTH-1:0]           hist_board,
    input  logic [3:0]                        hist_castle_mask,
    output logic                              hist_ready,
    output logic [REPDET_WIDTH-1:0]           hist_depth,
    output logic                              hist_full,
    output logic                              hist_empty,
    output logic                              hist_overflow,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*`BOARD_WIDTH-1:0]   req_board,
    input  logic [NUM_REQ*4-1:0]              req_castle_mask,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic                              rsp_rep,
    output logic [`BOARD_WIDTH-1:0]           rd_board,
    output logic [3:0]                        rd_castle_mask,
    output logic                              rd_board_valid,
    output logic                              rd_clear_sample,
    output logic [`BOARD_WIDTH-1:0]           rd_ram_board,
    output logic [3:0]                        rd_ram_castle_mask,
    output logic [REPDET_WIDTH-1:0]           rd_ram_wr_addr,
    output logic [REPDET_WIDTH-1:0]           rd_ram_depth,
    output logic                              rd_ram_wr_en,
    input  logic                              rd_thrice_rep,
    input  logic                              rd_thrice_rep_valid
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [REPDET_WIDTH-1:0] MAX_DEPTH = '1;
    localparam logic [REPDET_WIDTH-1:0] ONE       = REPDET_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                    state;
    state_t                    state_next;

    logic [REPDET_WIDTH-1:0]   depth;
    logic                      overflow;
    logic                      op_seen;
    logic                      hist_op;
    logic                      grant_ok;

    logic [GW-1:0]             grant;
    logic [GW-1:0]             rr_ptr;
    logic                      has_grant;
    logic [GW-1:0]             pick;
    logic                      pick_found;

    logic [`BOARD_WIDTH-1:0]   board_q;
    logic [3:0]                castle_q;
    logic [NUM_REQ-1:0]        rsp_valid_q;
    logic                      rsp_rep_q;
    logic                      clear_q;

    logic                      ram_wr_en_q;
    logic [REPDET_WIDTH-1:0]   ram_wr_addr_q;
    logic [`BOARD_WIDTH-1:0]   ram_board_q;
    logic [3:0]                ram_castle_q;

    // A history op counts as presented whenever any op line is high while
    // idle, even when it turns out to be a no-op (pop when empty, push when
    // full). Requests wait one extra cycle after any op so that the
    // registered RAM write reaches rep_det before the query is issued.
    assign hist_op  = (state == IDLE) && (hist_clear || hist_push || hist_pop);
    assign grant_ok = (state == IDLE) && (|req_valid) && !hist_op && !op_seen;

    assign hist_ready    = (state == IDLE);
    assign hist_depth    = depth;
    assign hist_full     = (depth == MAX_DEPTH);
    assign hist_empty    = (depth == '0);
    assign hist_overflow = overflow;

    assign rd_board           = board_q;
    assign rd_castle_mask     = castle_q;
    assign rd_board_valid     = (state == ISSUE);
    assign rd_clear_sample    = clear_q;
    assign rd_ram_board       = ram_board_q;
    assign rd_ram_castle_mask = ram_castle_q;
    assign rd_ram_wr_addr     = ram_wr_addr_q;
    assign rd_ram_wr_en       = ram_wr_en_q;
    assign rd_ram_depth       = depth;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rep   = rsp_rep_q;

    // Round-robin search. Before the first completed query there is no
    // "last grant", so the search starts at requester 0; afterwards it starts
    // one past the requester that was served last.
    always_comb begin
        int start_idx;
        int idx;
        start_idx  = 0;
        idx        = 0;
        pick       = '0;
        pick_found = 1'b0;
        if (has_grant) begin
            start_idx = (int'(rr_ptr) + 1) % NUM_REQ;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (start_idx + k) % NUM_REQ;
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick       = GW'(idx);
            end
        end
    end

    // Next-state logic and the one-cycle accept strobe for the granted requester.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (grant_ok && pick_found) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                req_ready[grant] = 1'b1;
                state_next       = WAIT;
            end
            WAIT: begin
                if (rd_thrice_rep_valid) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!rd_thrice_rep_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // History stack. The RAM write is registered so rep_det sees it one cycle
    // after the op, while the depth counter updates immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            depth         <= '0;
            overflow      <= 1'b0;
            op_seen       <= 1'b0;
            ram_wr_en_q   <= 1'b0;
            ram_wr_addr_q <= '0;
            ram_board_q   <= '0;
            ram_castle_q  <= '0;
        end else begin
            op_seen     <= hist_op;
            ram_wr_en_q <= 1'b0;
            if (hist_op) begin
                if (hist_clear) begin
                    depth    <= '0;
                    overflow <= 1'b0;
                end else if (hist_push && hist_pop) begin
                    ram_wr_en_q  <= 1'b1;
                    ram_board_q  <= hist_board;
                    ram_castle_q <= hist_castle_mask;
                    if (depth == '0) begin
                        ram_wr_addr_q <= '0;
                        depth         <= ONE;
                    end else begin
                        ram_wr_addr_q <= depth - ONE;
                    end
                end else if (hist_push) begin
                    if (depth == MAX_DEPTH) begin
                        overflow <= 1'b1;
                    end else begin
                        ram_wr_en_q   <= 1'b1;
                        ram_wr_addr_q <= depth;
                        ram_board_q   <= hist_board;
                        ram_castle_q  <= hist_castle_mask;
                        depth         <= depth + ONE;
                    end
                end else if (hist_pop) begin
                    if (depth != '0) begin
                        depth <= depth - ONE;
                    end
                end
            end
        end
    end

    // Query path: latch the granted slice, return the verdict as a one-cycle
    // strobe, and only move the round-robin pointer once rep_det has dropped
    // its valid so the next grant cannot overlap the old verdict.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant       <= '0;
            rr_ptr      <= '0;
            has_grant   <= 1'b0;
            board_q     <= '0;
            castle_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rep_q   <= 1'b0;
            clear_q     <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            clear_q     <= 1'b0;
            if (state == IDLE && grant_ok && pick_found) begin
                grant    <= pick;
                board_q  <= req_board[int'(pick)*`BOARD_WIDTH +: `BOARD_WIDTH];
                castle_q <= req_castle_mask[int'(pick)*4 +: 4];
            end
            if (state == WAIT && rd_thrice_rep_valid) begin
                rsp_valid_q[grant] <= 1'b1;
                rsp_rep_q          <= rd_thrice_rep;
                clear_q            <= 1'b1;
            end
            if (state == DRAIN && !rd_thrice_rep_valid) begin
                rr_ptr    <= grant;
                has_grant <= 1'b1;
            end
        end
    end

endmodule
